// File: rtl/sap_control_sequencer.sv
// rtl/sap_control_sequencer.sv - SAP-U microcoded T-state sequencer with flag register
module sap_control_sequencer #(
    parameter int LAST_STEP = 4
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] opcode,
    input  logic       carry_in,
    input  logic       zero_in,
    output logic [2:0] step,
    output logic       pc_oe_n,
    output logic       ram_oe_n,
    output logic       ir_oe_n,
    output logic       a_oe_n,
    output logic       alu_oe_n,
    output logic       mar_ld_n,
    output logic       ir_ld_n,
    output logic       a_ld_n,
    output logic       b_ld_n,
    output logic       out_ld_n,
    output logic       ram_we,
    output logic       pc_inc,
    output logic       pc_ld,
    output logic       alu_sub,
    output logic       flag_c,
    output logic       flag_z,
    output logic       halted
);

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;
    localparam logic [2:0] LAST   = 3'(LAST_STEP);

    logic [2:0] r_step;
    logic       r_flag_c;
    logic       r_flag_z;
    logic       r_halted;

    logic w_pc_oe, w_ram_oe, w_ir_oe, w_a_oe, w_alu_oe;
    logic w_mar_ld, w_ir_ld, w_a_ld, w_b_ld, w_out_ld;
    logic w_ram_we, w_pc_inc, w_pc_ld, w_alu_sub;
    logic w_end, w_hlt, w_flag_ld;

    // Each step drives at most one *_oe by construction; clr low or halt masks everything.
    always_comb begin
        w_pc_oe   = 1'b0;
        w_ram_oe  = 1'b0;
        w_ir_oe   = 1'b0;
        w_a_oe    = 1'b0;
        w_alu_oe  = 1'b0;
        w_mar_ld  = 1'b0;
        w_ir_ld   = 1'b0;
        w_a_ld    = 1'b0;
        w_b_ld    = 1'b0;
        w_out_ld  = 1'b0;
        w_ram_we  = 1'b0;
        w_pc_inc  = 1'b0;
        w_pc_ld   = 1'b0;
        w_alu_sub = 1'b0;
        w_end     = 1'b1;
        w_hlt     = 1'b0;
        w_flag_ld = 1'b0;
        if (clr && !r_halted) begin
            case (r_step)
                3'd0: begin
                    w_pc_oe  = 1'b1;
                    w_mar_ld = 1'b1;
                    w_end    = 1'b0;
                end
                3'd1: begin
                    w_ram_oe = 1'b1;
                    w_ir_ld  = 1'b1;
                    w_pc_inc = 1'b1;
                    w_end    = 1'b0;
                end
                3'd2: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            w_ir_oe  = 1'b1;
                            w_mar_ld = 1'b1;
                            w_end    = 1'b0;
                        end
                        OP_LDI: begin
                            w_ir_oe = 1'b1;
                            w_a_ld  = 1'b1;
                        end
                        OP_JMP: begin
                            w_ir_oe = 1'b1;
                            w_pc_ld = 1'b1;
                        end
                        OP_JC: begin
                            w_ir_oe = r_flag_c;
                            w_pc_ld = r_flag_c;
                        end
                        OP_JZ: begin
                            w_ir_oe = r_flag_z;
                            w_pc_ld = r_flag_z;
                        end
                        OP_OUT: begin
                            w_a_oe   = 1'b1;
                            w_out_ld = 1'b1;
                        end
                        OP_HLT:  w_hlt = 1'b1;
                        default: ;
                    endcase
                end
                3'd3: begin
                    case (opcode)
                        OP_LDA: begin
                            w_ram_oe = 1'b1;
                            w_a_ld   = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            w_ram_oe  = 1'b1;
                            w_b_ld    = 1'b1;
                            w_alu_sub = (opcode == OP_SUB);
                            w_end     = 1'b0;
                        end
                        OP_STA: begin
                            w_a_oe   = 1'b1;
                            w_ram_we = 1'b1;
                        end
                        default: ;
                    endcase
                end
                3'd4: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        w_alu_oe  = 1'b1;
                        w_a_ld    = 1'b1;
                        w_alu_sub = (opcode == OP_SUB);
                        w_flag_ld = 1'b1;
                    end
                end
                default: ;
            endcase
            if (r_step >= LAST) begin
                w_end = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_step   <= 3'd0;
            r_flag_c <= 1'b0;
            r_flag_z <= 1'b0;
            r_halted <= 1'b0;
        end else if (r_halted) begin
            r_step <= 3'd0;
        end else begin
            r_step <= w_end ? 3'd0 : r_step + 3'd1;
            if (w_flag_ld) begin
                r_flag_c <= carry_in;
                r_flag_z <= zero_in;
            end
            if (w_hlt) begin
                r_halted <= 1'b1;
            end
        end
    end

    assign step     = r_step;
    assign flag_c   = r_flag_c;
    assign flag_z   = r_flag_z;
    assign halted   = r_halted;
    assign pc_oe_n  = ~w_pc_oe;
    assign ram_oe_n = ~w_ram_oe;
    assign ir_oe_n  = ~w_ir_oe;
    assign a_oe_n   = ~w_a_oe;
    assign alu_oe_n = ~w_alu_oe;
    assign mar_ld_n = ~w_mar_ld;
    assign ir_ld_n  = ~w_ir_ld;
    assign a_ld_n   = ~w_a_ld;
    assign b_ld_n   = ~w_b_ld;
    assign out_ld_n = ~w_out_ld;
    assign ram_we   = w_ram_we;
    assign pc_inc   = w_pc_inc;
    assign pc_ld    = w_pc_ld;
    assign alu_sub  = w_alu_sub;

endmodule
